// File: rtl/univ_shift_reg.sv
// ============================================================================
// Module   : univ_shift_reg
// Purpose  : Parametrised universal shift register with hold, shift-right,
//            shift-left and parallel-load modes, plus a load-then-shift-N
//            burst sequencer with start/busy/done handshake.
// Options  : SHREG_ROTATE_EN - all shifts rotate instead of taking the serial inputs
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module univ_shift_reg #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             sin_r,
   input  logic             sin_l,
   input  logic [WIDTH-1:0] pin,
   input  logic             start,
   input  logic             dir,
   input  logic [CNT_W-1:0] nshift,
   output logic [WIDTH-1:0] q,
   output logic             sout_r,
   output logic             sout_l,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(WIDTH);
   localparam logic [1:0]       c_MODE_SHR  = 2'b01;
   localparam logic [1:0]       c_MODE_SHL  = 2'b10;
   localparam logic [1:0]       c_MODE_LOAD = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_nxt;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_nxt;
   logic             r_dir;
   logic             w_dir_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic             w_fill_r;
   logic             w_fill_l;
   logic [WIDTH-1:0] w_shr;
   logic [WIDTH-1:0] w_shl;

`ifdef SHREG_ROTATE_EN
   logic w_unused_sin;
   assign w_unused_sin = sin_r ^ sin_l;
   assign w_fill_r     = r_q[0];
   assign w_fill_l     = r_q[WIDTH-1];
`else
   assign w_fill_r     = sin_r;
   assign w_fill_l     = sin_l;
`endif

   assign w_shr = {w_fill_r, r_q[WIDTH-1:1]};
   assign w_shl = {r_q[WIDTH-2:0], w_fill_l};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_q     <= '0;
         r_count <= '0;
         r_dir   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_q     <= w_q_nxt;
         r_count <= w_count_nxt;
         r_dir   <= w_dir_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_q_nxt     = r_q;
      w_count_nxt = r_count;
      w_dir_nxt   = r_dir;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_q_nxt     = pin;
               w_dir_nxt   = dir;
               w_count_nxt = (nshift > c_MAX_CNT) ? c_MAX_CNT : nshift;
               w_state_nxt = S_LOAD;
            end else if (en) begin
               case (mode)
                  c_MODE_SHR:  w_q_nxt = w_shr;
                  c_MODE_SHL:  w_q_nxt = w_shl;
                  c_MODE_LOAD: w_q_nxt = pin;
                  default:     w_q_nxt = r_q;
               endcase
            end
         end
         // The loaded word sits for one cycle so a zero-length burst still pulses done.
         S_LOAD: begin
            if (r_count == '0) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            w_q_nxt     = r_dir ? w_shl : w_shr;
            w_count_nxt = r_count - CNT_W'(1);
            if (r_count == CNT_W'(1)) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign q      = r_q;
   assign sout_r = r_q[0];
   assign sout_l = r_q[WIDTH-1];
   assign busy   = (r_state != S_IDLE);
   assign done   = r_done;

endmodule

`default_nettype wire
